// File: rtl/paint_pkg.sv
// rtl/paint_pkg.sv - shared paint RAM color codes and frame geometry
package paint_pkg;

    typedef enum logic [2:0] {
        ERASE  = 3'd0,
        WHITE  = 3'd1,
        BLACK  = 3'd2,
        RED    = 3'd3,
        BLUE   = 3'd4,
        YELLOW = 3'd5,
        GREEN  = 3'd6,
        PURPLE = 3'd7
    } color_e;

    localparam int PAINT_DEPTH  = 640 * 480;
    localparam int PAINT_ADDR_W = 19;

endpackage

// File: rtl/paint_rr_arb.sv
// rtl/paint_rr_arb.sv - 2-way write arbiter, bit0 = brush, bit1 = stamp
// PAINT_WR_ROUND_ROBIN_EN selects round-robin; otherwise brush has fixed priority.
module paint_rr_arb (
`ifdef PAINT_WR_ROUND_ROBIN_EN
    input  logic       clk,
    input  logic       reset,
`endif
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

`ifdef PAINT_WR_ROUND_ROBIN_EN
    // ptr_q == 0 favors brush, 1 favors stamp; it flips to the other port after each grant
    logic ptr_q;

    always_comb begin
        gnt_o = 2'b00;
        if (!ptr_q) begin
            if (req_i[0])      gnt_o = 2'b01;
            else if (req_i[1]) gnt_o = 2'b10;
        end else begin
            if (req_i[1])      gnt_o = 2'b10;
            else if (req_i[0]) gnt_o = 2'b01;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)         ptr_q <= 1'b0;
        else if (gnt_o[0]) ptr_q <= 1'b1;
        else if (gnt_o[1]) ptr_q <= 1'b0;
    end
`else
    always_comb begin
        gnt_o = 2'b00;
        if (req_i[0])      gnt_o = 2'b01;
        else if (req_i[1]) gnt_o = 2'b10;
    end
`endif

endmodule

// File: rtl/paint_wr_arbiter.sv
// rtl/paint_wr_arbiter.sv - paint RAM write port: brush/stamp arbitration plus full-frame clear
// PAINT_WR_ROUND_ROBIN_EN selects round-robin arbitration between brush and stamp.
module paint_wr_arbiter
    import paint_pkg::*;
#(
    parameter int ADDR_W = PAINT_ADDR_W,
    parameter int DEPTH  = PAINT_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_req,
    input  logic              brush_req,
    input  logic [ADDR_W-1:0] brush_addr,
    input  logic [2:0]        brush_data,
    output logic              brush_gnt,
    input  logic              stamp_req,
    input  logic [ADDR_W-1:0] stamp_addr,
    input  logic [2:0]        stamp_data,
    output logic              stamp_gnt,
    output logic              ram_wren,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [2:0]        ram_wr_data,
    output logic              clear_busy,
    output logic              clear_done
);

    typedef enum logic {
        S_IDLE,
        S_CLEAR
    } state_e;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              ram_wren_q;
    logic [ADDR_W-1:0] ram_wr_addr_q;
    logic [2:0]        ram_wr_data_q;
    logic              clear_done_q;

    logic              arb_en;
    logic [1:0]        arb_req;
    logic [1:0]        arb_gnt;

    // A clear request in IDLE takes the cycle, so pending requests wait for the sweep
    assign arb_en  = !reset && (state_q == S_IDLE) && !clear_req;
    assign arb_req = {stamp_req, brush_req} & {2{arb_en}};

    paint_rr_arb u_arb (
`ifdef PAINT_WR_ROUND_ROBIN_EN
        .clk   (clk),
        .reset (reset),
`endif
        .req_i (arb_req),
        .gnt_o (arb_gnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            ram_wren_q    <= 1'b0;
            ram_wr_addr_q <= '0;
            ram_wr_data_q <= 3'b000;
            clear_done_q  <= 1'b0;
        end else begin
            ram_wren_q   <= 1'b0;
            clear_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (clear_req) begin
                        state_q <= S_CLEAR;
                        cnt_q   <= '0;
                    end else if (arb_gnt[0]) begin
                        ram_wren_q    <= 1'b1;
                        ram_wr_addr_q <= brush_addr;
                        ram_wr_data_q <= brush_data;
                    end else if (arb_gnt[1]) begin
                        ram_wren_q    <= 1'b1;
                        ram_wr_addr_q <= stamp_addr;
                        ram_wr_data_q <= stamp_data;
                    end
                end
                S_CLEAR: begin
                    ram_wren_q    <= 1'b1;
                    ram_wr_addr_q <= cnt_q;
                    ram_wr_data_q <= ERASE;
                    if (cnt_q == LAST_ADDR) begin
                        state_q      <= S_IDLE;
                        cnt_q        <= '0;
                        clear_done_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + ADDR_W'(1);
                    end
                end
            endcase
        end
    end

    assign brush_gnt   = arb_gnt[0];
    assign stamp_gnt   = arb_gnt[1];
    assign ram_wren    = ram_wren_q;
    assign ram_wr_addr = ram_wr_addr_q;
    assign ram_wr_data = ram_wr_data_q;
    assign clear_busy  = (state_q == S_CLEAR);
    assign clear_done  = clear_done_q;

endmodule

// File: doc/paint_wr_arbiter.md
PAINT_WR_ARBITER -- requirements
Module: paint_wr_arbiter

Interface
REQ-001 Parameter ADDR_W, default 19: width of every paint RAM address.
REQ-002 Parameter DEPTH, default 307200 (640*480): number of pixel locations swept by a clear.
REQ-003 clk  in  1  clock; all state updates on posedge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 clear_req  in  1  single-cycle request to erase the whole RAM.
REQ-006 brush_req  in  1  brush (port A) write request.
REQ-007 brush_addr  in  ADDR_W  port A pixel address.
REQ-008 brush_data  in  3  port A color code.
REQ-009 brush_gnt  out  1  port A request accepted this cycle.
REQ-010 stamp_req  in  1  stamp (port B) write request.
REQ-011 stamp_addr  in  ADDR_W  port B pixel address.
REQ-012 stamp_data  in  3  port B color code.
REQ-013 stamp_gnt  out  1  port B request accepted this cycle.
REQ-014 ram_wren  out  1  registered write enable to paint RAM.
REQ-015 ram_wr_addr  out  ADDR_W  registered write address.
REQ-016 ram_wr_data  out  3  registered write color code.
REQ-017 clear_busy  out  1  high while the clear sweep runs.
REQ-018 clear_done  out  1  one-cycle pulse after the last clear write issues.

Function
REQ-019 FSM states IDLE and CLEAR only; reset enters IDLE.
REQ-020 IDLE + clear_req -> CLEAR next cycle; clear counter loaded with 0; no grant issued that cycle (clear beats pending requests).
REQ-021 CLEAR: each cycle ram_wren=1, ram_wr_addr=counter, ram_wr_data=3'b000 (erase), counter +1.
REQ-022 CLEAR: when counter==DEPTH-1 that write issues, clear_done pulses the following cycle, FSM returns to IDLE; exactly DEPTH writes, no wrap.
REQ-023 clear_req while in CLEAR is ignored; sweep does not restart.
REQ-024 clear_busy = (state==CLEAR); brush_gnt, stamp_gnt held 0 in CLEAR.
REQ-025 IDLE: at most one grant per cycle; gnt is combinational from req and arbiter state, same cycle as the req.
REQ-026 Granted port's addr/data registered onto ram_wr_* with ram_wren=1 next cycle (latency 1); no grant -> ram_wren=0 next cycle, addr/data hold.
REQ-027 Requester holds req/addr/data stable until gnt; deasserting without gnt is legal and causes no write.
REQ-028 Addresses >= DEPTH are forwarded unchanged; range checking is the requester's responsibility.

Reset
REQ-029 reset: state=IDLE, counter=0, ram_wren=0, ram_wr_addr=0, ram_wr_data=0, clear_busy=0, clear_done=0, gnts=0, round-robin pointer favors brush.
REQ-030 reset mid-CLEAR aborts the sweep; no clear_done pulse.
REQ-031 reset overrides clear_req and all reqs in the same cycle.

Configuration
REQ-032 PAINT_WR_ROUND_ROBIN_EN defined: both req high -> grant alternates; pointer moves to the other port after each grant.
REQ-033 PAINT_WR_ROUND_ROBIN_EN undefined: fixed priority, brush always wins ties; no pointer state.

Structure
REQ-034 Shared package paint_pkg holds: 3-bit color code enum (ERASE, WHITE, BLACK, RED, BLUE, YELLOW, GREEN, PURPLE = 0..7), PAINT_DEPTH=640*480, PAINT_ADDR_W=19.
REQ-035 FSM state typedef local to module.
REQ-036 One sub-module paint_rr_arb: 2-way arbiter (req[1:0] -> gnt[1:0]), round-robin vs fixed selected by the macro.

Verification
REQ-037 reset; brush_req=1, addr=5, data=3 one cycle -> brush_gnt=1 same cycle; next cycle ram_wren=1, addr=5, data=3.
REQ-038 Both req held 4 cycles, macro on -> gnts B,S,B,S; macro off -> B,B,B,B.
REQ-039 clear_req with DEPTH=16 -> clear_busy 16 cycles, writes addr 0..15 data 0, clear_done one cycle later, back to IDLE.
REQ-040 clear_req and brush_req same cycle -> brush_gnt=0 throughout clear; brush granted first IDLE cycle after.
REQ-041 reset asserted at clear write 7 of 16 -> ram_wren=0, clear_busy=0 next cycle, clear_done never pulses.
REQ-042 clear_req re-pulsed mid-sweep -> still exactly 16 writes, single clear_done.
